// File: rtl/break_select_engine_pkg.sv
// Shared types and helpers for the WalkSAT break-count / literal-selection engine.
package break_select_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SELECT  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [1:0] KIND_FREEBIE = 2'd0;
  localparam logic [1:0] KIND_GREEDY  = 2'd1;
  localparam logic [1:0] KIND_RANDOM  = 2'd2;
  localparam logic [1:0] KIND_NONE    = 2'd3;

  localparam logic [31:0] P_DEFAULT = 32'h6E14_7AE0;

  // Literal-index width; a 1-literal-wide index still needs one bit.
  function automatic int calc_nb(input int nsat);
    int w;
    w = $clog2(nsat);
    return (w < 1) ? 1 : w;
  endfunction

  // Break-value width, wide enough to hold MC without saturating.
  function automatic int calc_mcb(input int mc);
    return $clog2(mc + 1);
  endfunction

endpackage

// File: rtl/break_select_engine_if.sv
// Literal-beat input stream and selection-result output stream of the engine.
interface break_select_engine_if #(
  parameter int MC  = 20,
  parameter int NB  = 2,
  parameter int MCB = 5
);
  logic           lit_valid_i;
  logic           lit_ready_o;
  logic           lit_last_i;
  logic           lit_en_i;
  logic [MC-1:0]  clause_broken_i;
  logic [MC-1:0]  mask_bits_i;
  logic [31:0]    rnd_i;
  logic           sel_valid_o;
  logic           sel_ready_i;
  logic [NB-1:0]  select_o;
  logic [MCB-1:0] break_value_o;
  logic [MC-1:0]  clause_broken_bits_o;
  logic [1:0]     sel_kind_o;

  modport master (
    output lit_valid_i, lit_last_i, lit_en_i, clause_broken_i, mask_bits_i, rnd_i, sel_ready_i,
    input  lit_ready_o, sel_valid_o, select_o, break_value_o, clause_broken_bits_o, sel_kind_o
  );

  modport slave (
    input  lit_valid_i, lit_last_i, lit_en_i, clause_broken_i, mask_bits_i, rnd_i, sel_ready_i,
    output lit_ready_o, sel_valid_o, select_o, break_value_o, clause_broken_bits_o, sel_kind_o
  );
endinterface

// File: rtl/break_select_engine_popcount.sv
// Masked popcount: break value of one literal beat plus its masked broken bits.
module bv_popcount #(
  parameter int MC  = 20,
  parameter int MCB = 5
) (
  input  logic [MC-1:0]  broken,
  input  logic [MC-1:0]  mask,
  output logic [MC-1:0]  masked,
  output logic [MCB-1:0] count
);

  // Count the broken bits that fall on occupied clause positions.
  always_comb begin
    masked = broken & mask;
    count  = '0;
    for (int i = 0; i < MC; i++) begin
      count = count + MCB'(masked[i]);
    end
  end

endmodule

// File: rtl/break_select_engine.sv
// WalkSAT break-count and literal-selection engine.
// Collects up to NSAT literal beats, then picks a freebie / random / greedy literal.
// Optional feature macro: BREAK_SELECT_STATS_EN adds per-kind selection counters.
module break_select_engine
  import break_select_pkg::*;
#(
  parameter int          NSAT = 3,
  parameter int          MC   = 20,
  parameter int          MCB  = calc_mcb(MC),
  parameter int          NB   = calc_nb(NSAT),
  parameter logic [31:0] P    = P_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  break_select_engine_if.slave bus
`ifdef BREAK_SELECT_STATS_EN
  ,
  output logic [31:0] stat_freebie_o,
  output logic [31:0] stat_greedy_o,
  output logic [31:0] stat_random_o
`endif
);

  state_t          state, state_next;
  logic [NB-1:0]   idx;
  logic [MCB-1:0]  slot_bv   [NSAT];
  logic [MC-1:0]   slot_bits [NSAT];
  logic [NSAT-1:0] slot_en, slot_filled, slot_valid;

  logic [MC-1:0]   beat_bits;
  logic [MCB-1:0]  beat_bv;
  logic            lit_ready, accept, close_clause, hand_off;

  logic [NB-1:0]   pick_idx;
  logic [1:0]      pick_kind;
  logic [MCB-1:0]  pick_bv, best_bv;
  logic [MC-1:0]   pick_bits;
  logic            found;
  int              rnd_start;

  logic [NB-1:0]   select_r;
  logic [MCB-1:0]  bv_r;
  logic [MC-1:0]   bits_r;
  logic [1:0]      kind_r;

  bv_popcount #(.MC(MC), .MCB(MCB)) u_popcount (
    .broken (bus.clause_broken_i),
    .mask   (bus.mask_bits_i),
    .masked (beat_bits),
    .count  (beat_bv)
  );

  assign lit_ready    = (state == COLLECT);
  assign accept       = bus.lit_valid_i & lit_ready;
  assign close_clause = accept & (bus.lit_last_i | (idx == NB'(NSAT - 1)));
  assign hand_off     = (state == HOLD) & bus.sel_ready_i;
  assign slot_valid   = slot_filled & slot_en;
  assign rnd_start    = int'(bus.rnd_i[NB-1:0]) % NSAT;

  assign bus.lit_ready_o          = lit_ready;
  assign bus.sel_valid_o          = (state == HOLD);
  assign bus.select_o             = select_r;
  assign bus.break_value_o        = bv_r;
  assign bus.clause_broken_bits_o = bits_r;
  assign bus.sel_kind_o           = kind_r;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_next;
  end

  // Next state: collect until the clause closes, one select cycle, hold until taken.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (close_clause) state_next = SELECT;
      SELECT:  state_next = HOLD;
      HOLD:    if (hand_off) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Slot storage: one entry per accepted beat, wiped when the result is handed off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      slot_en     <= '0;
      slot_filled <= '0;
      for (int i = 0; i < NSAT; i++) begin
        slot_bv[i]   <= '0;
        slot_bits[i] <= '0;
      end
    end else if (hand_off) begin
      idx         <= '0;
      slot_en     <= '0;
      slot_filled <= '0;
      for (int i = 0; i < NSAT; i++) begin
        slot_bv[i]   <= '0;
        slot_bits[i] <= '0;
      end
    end else if (accept) begin
      slot_bv[idx]     <= beat_bv;
      slot_bits[idx]   <= beat_bits;
      slot_en[idx]     <= bus.lit_en_i;
      slot_filled[idx] <= 1'b1;
      idx              <= idx + 1'b1;
    end
  end

  // Selection: freebie first, then noise-driven random walk, else minimum break value.
  always_comb begin
    pick_idx  = '0;
    pick_kind = KIND_NONE;
    found     = 1'b0;
    best_bv   = '1;
    if (slot_valid != '0) begin
      for (int i = 0; i < NSAT; i++) begin
        if (!found && slot_valid[i] && (slot_bv[i] == '0)) begin
          found    = 1'b1;
          pick_idx = NB'(i);
        end
      end
      if (found) begin
        pick_kind = KIND_FREEBIE;
      end else if (bus.rnd_i < P) begin
        pick_kind = KIND_RANDOM;
        for (int k = 0; k < NSAT; k++) begin
          if (!found && slot_valid[(rnd_start + k) % NSAT]) begin
            found    = 1'b1;
            pick_idx = NB'((rnd_start + k) % NSAT);
          end
        end
      end else begin
        pick_kind = KIND_GREEDY;
        for (int i = 0; i < NSAT; i++) begin
          if (slot_valid[i] && (!found || (slot_bv[i] < best_bv))) begin
            found    = 1'b1;
            best_bv  = slot_bv[i];
            pick_idx = NB'(i);
          end
        end
      end
    end
    pick_bv   = (pick_kind == KIND_NONE) ? '0 : slot_bv[pick_idx];
    pick_bits = (pick_kind == KIND_NONE) ? '0 : slot_bits[pick_idx];
  end

  // Result register: captured in SELECT, held through HOLD, cleared after hand-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      select_r <= '0;
      bv_r     <= '0;
      bits_r   <= '0;
      kind_r   <= '0;
    end else if (state == SELECT) begin
      select_r <= pick_idx;
      bv_r     <= pick_bv;
      bits_r   <= pick_bits;
      kind_r   <= pick_kind;
    end else if (hand_off) begin
      select_r <= '0;
      bv_r     <= '0;
      bits_r   <= '0;
      kind_r   <= '0;
    end
  end

`ifdef BREAK_SELECT_STATS_EN
  // Per-kind counters bumped when a result is handed off; none-valid is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_freebie_o <= '0;
      stat_greedy_o  <= '0;
      stat_random_o  <= '0;
    end else if (hand_off) begin
      if (kind_r == KIND_FREEBIE) stat_freebie_o <= stat_freebie_o + 32'd1;
      if (kind_r == KIND_GREEDY)  stat_greedy_o  <= stat_greedy_o + 32'd1;
      if (kind_r == KIND_RANDOM)  stat_random_o  <= stat_random_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_break_select_engine.sv
// Testbench for break_select_engine: directed clauses, scoreboard checked by a monitor.
module tb_break_select_engine;
  import break_select_pkg::*;

  localparam int          NSAT = 3;
  localparam int          MC   = 20;
  localparam int          NB   = 2;
  localparam int          MCB  = 5;
  localparam logic [31:0] PTH  = 32'h6E14_7AE0;

  localparam logic [MC-1:0] ALL  = 20'hFFFFF;
  localparam logic [MC-1:0] V1   = 20'h00100;
  localparam logic [MC-1:0] V2   = 20'h00030;
  localparam logic [MC-1:0] V3   = 20'h00007;
  localparam logic [MC-1:0] V5   = 20'h0001F;
  localparam logic [MC-1:0] ZERO = 20'h00000;

  typedef struct packed {
    logic [NB-1:0]  sel;
    logic [MCB-1:0] bv;
    logic [MC-1:0]  bits;
    logic [1:0]     kind;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  break_select_engine_if #(.MC(MC), .NB(NB), .MCB(MCB)) bus ();

`ifdef BREAK_SELECT_STATS_EN
  logic [31:0] stat_freebie, stat_greedy, stat_random;
`endif

  break_select_engine #(.NSAT(NSAT), .MC(MC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef BREAK_SELECT_STATS_EN
    ,
    .stat_freebie_o (stat_freebie),
    .stat_greedy_o  (stat_greedy),
    .stat_random_o  (stat_random)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  bit   seen = 1'b0;

  logic [MC-1:0] b_broken [4];
  logic [MC-1:0] b_mask   [4];
  logic          b_en     [4];
  logic          b_last   [4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic setBeat(input int i, input logic [MC-1:0] broken, input logic [MC-1:0] mask,
                         input logic en, input logic last);
    b_broken[i] = broken;
    b_mask[i]   = mask;
    b_en[i]     = en;
    b_last[i]   = last;
  endtask

  function automatic exp_t mkExp(input int sel, input int bv, input logic [MC-1:0] bits, input int kind);
    exp_t e;
    e.sel  = NB'(sel);
    e.bv   = MCB'(bv);
    e.bits = bits;
    e.kind = 2'(kind);
    return e;
  endfunction

  // Send one clause, check latency, optionally stall the result, then accept it.
  task automatic applyStimulus(input int nbeats, input logic [31:0] rnd, input exp_t e, input int hold);
    int waited;
    exp_q.push_back(e);
    bus.rnd_i = rnd;
    for (int i = 0; i < nbeats; i++) begin
      bus.lit_valid_i     = 1'b1;
      bus.clause_broken_i = b_broken[i];
      bus.mask_bits_i     = b_mask[i];
      bus.lit_en_i        = b_en[i];
      bus.lit_last_i      = b_last[i];
      @(negedge clk);
    end
    bus.lit_valid_i = 1'b0;
    bus.lit_last_i  = 1'b0;
    checkOutput("latency_select_cycle", 32'(bus.sel_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("latency_hold_cycle", 32'(bus.sel_valid_o), 32'd1);
    waited = 0;
    while (!bus.sel_valid_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.sel_valid_o) begin
      n_checks++;
      $display("[TB] FAIL result_timeout: got sel_valid_o=0, want 1 within 20 cycles");
    end
    for (int h = 0; h < hold; h++) begin
      bus.lit_valid_i = 1'b1;
      checkOutput("hold_valid", 32'(bus.sel_valid_o), 32'd1);
      checkOutput("hold_lit_ready", 32'(bus.lit_ready_o), 32'd0);
      checkOutput("hold_select", 32'(bus.select_o), 32'(e.sel));
      checkOutput("hold_bv", 32'(bus.break_value_o), 32'(e.bv));
      checkOutput("hold_bits", 32'(bus.clause_broken_bits_o), 32'(e.bits));
      @(negedge clk);
    end
    bus.lit_valid_i = 1'b0;
    bus.sel_ready_i = 1'b1;
    @(negedge clk);
    bus.sel_ready_i = 1'b0;
    checkOutput("post_handoff_valid", 32'(bus.sel_valid_o), 32'd0);
    checkOutput("post_handoff_ready", 32'(bus.lit_ready_o), 32'd1);
  endtask

  // Monitor: compare each newly presented result against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.sel_valid_o && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_result: got a result, want none pending");
        end else begin
          e = exp_q.pop_front();
          checkOutput("mon_select", 32'(bus.select_o), 32'(e.sel));
          checkOutput("mon_bv", 32'(bus.break_value_o), 32'(e.bv));
          checkOutput("mon_bits", 32'(bus.clause_broken_bits_o), 32'(e.bits));
          checkOutput("mon_kind", 32'(bus.sel_kind_o), 32'(e.kind));
        end
      end else if (!bus.sel_valid_o) begin
        seen = 1'b0;
      end
    end
  end

  // Watchdog so a stuck design still terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n             = 1'b0;
    bus.lit_valid_i     = 1'b0;
    bus.lit_last_i      = 1'b0;
    bus.lit_en_i        = 1'b0;
    bus.clause_broken_i = '0;
    bus.mask_bits_i     = '0;
    bus.rnd_i           = '0;
    bus.sel_ready_i     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_sel_valid", 32'(bus.sel_valid_o), 32'd0);
    checkOutput("reset_select", 32'(bus.select_o), 32'd0);
    checkOutput("reset_kind", 32'(bus.sel_kind_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_release_ready", 32'(bus.lit_ready_o), 32'd1);

    $display("[TB] freebie with masked bits, explicit last");
    setBeat(0, 20'hF000F, 20'h0FFFF, 1'b1, 1'b0);
    setBeat(1, 20'hF0000, 20'h0FFFF, 1'b1, 1'b0);
    setBeat(2, V2, ALL, 1'b1, 1'b1);
    applyStimulus(3, 32'hFFFFFFFF, mkExp(1, 0, ZERO, 0), 0);

    $display("[TB] greedy tie, auto-close, stalled result");
    setBeat(0, V3, ALL, 1'b1, 1'b0);
    setBeat(1, V1, ALL, 1'b1, 1'b0);
    setBeat(2, 20'h00200, ALL, 1'b1, 1'b0);
    applyStimulus(3, 32'hFFFFFFFF, mkExp(1, 1, V1, 1), 5);

    $display("[TB] random start on disabled slot wraps");
    setBeat(0, V3, ALL, 1'b1, 1'b0);
    setBeat(1, V1, ALL, 1'b1, 1'b0);
    setBeat(2, V2, ALL, 1'b0, 1'b1);
    applyStimulus(3, 32'h00000002, mkExp(0, 3, V3, 2), 0);

    $display("[TB] short clause, unfilled slot ignored");
    setBeat(0, V5, ALL, 1'b1, 1'b0);
    setBeat(1, V2, ALL, 1'b1, 1'b1);
    applyStimulus(2, 32'hFFFFFFFF, mkExp(1, 2, V2, 1), 0);

    $display("[TB] no enabled literal");
    setBeat(0, V3, ALL, 1'b0, 1'b0);
    setBeat(1, ZERO, ALL, 1'b0, 1'b0);
    setBeat(2, V2, ALL, 1'b0, 1'b1);
    applyStimulus(3, 32'h00000000, mkExp(0, 0, ZERO, 3), 0);

    $display("[TB] noise threshold boundary");
    setBeat(0, V2, ALL, 1'b1, 1'b0);
    setBeat(1, V1, ALL, 1'b1, 1'b0);
    setBeat(2, V3, ALL, 1'b1, 1'b1);
    applyStimulus(3, PTH - 32'd1, mkExp(0, 2, V2, 2), 0);
    applyStimulus(3, PTH, mkExp(1, 1, V1, 1), 0);
    applyStimulus(3, 32'h00000001, mkExp(1, 1, V1, 2), 0);

    $display("[TB] freebie wins over noise");
    setBeat(0, V1, ALL, 1'b1, 1'b0);
    setBeat(1, V2, ALL, 1'b1, 1'b0);
    setBeat(2, ZERO, ALL, 1'b1, 1'b1);
    applyStimulus(3, 32'h00000000, mkExp(2, 0, ZERO, 0), 0);

    $display("[TB] reset mid-clause");
    bus.lit_valid_i     = 1'b1;
    bus.clause_broken_i = ZERO;
    bus.mask_bits_i     = ALL;
    bus.lit_en_i        = 1'b1;
    bus.lit_last_i      = 1'b0;
    @(negedge clk);
    bus.lit_valid_i = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_sel_valid", 32'(bus.sel_valid_o), 32'd0);
    checkOutput("midreset_select", 32'(bus.select_o), 32'd0);
    checkOutput("midreset_bv", 32'(bus.break_value_o), 32'd0);
    checkOutput("midreset_bits", 32'(bus.clause_broken_bits_o), 32'd0);
    checkOutput("midreset_kind", 32'(bus.sel_kind_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_release_ready", 32'(bus.lit_ready_o), 32'd1);
    setBeat(0, V3, ALL, 1'b1, 1'b0);
    setBeat(1, V2, ALL, 1'b1, 1'b1);
    applyStimulus(2, 32'hFFFFFFFF, mkExp(1, 2, V2, 1), 0);

`ifdef BREAK_SELECT_STATS_EN
    $display("[TB] statistics counters");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    setBeat(0, V1, ALL, 1'b1, 1'b0);
    setBeat(1, ZERO, ALL, 1'b1, 1'b0);
    setBeat(2, V2, ALL, 1'b1, 1'b1);
    for (int n = 0; n < 3; n++) applyStimulus(3, 32'hFFFFFFFF, mkExp(1, 0, ZERO, 0), 0);
    setBeat(0, V2, ALL, 1'b1, 1'b0);
    setBeat(1, V1, ALL, 1'b1, 1'b0);
    setBeat(2, V3, ALL, 1'b1, 1'b1);
    for (int n = 0; n < 2; n++) applyStimulus(3, 32'h00000001, mkExp(1, 1, V1, 2), 0);
    checkOutput("stat_freebie", stat_freebie, 32'd3);
    checkOutput("stat_random", stat_random, 32'd2);
    checkOutput("stat_greedy", stat_greedy, 32'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
